// File: rtl/fb_pixel_writer_pkg.sv
// Shared defaults and FSM encoding for the framebuffer pixel writer.
package fb_pixel_writer_pkg;

  localparam int DEF_BITS_PER_PIXEL = 16;
  localparam int DEF_WIDTH_BITS     = 6;
  localparam int DEF_HEIGHT_BITS    = 5;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

endpackage

// File: rtl/fb_pixel_writer_sync.sv
// Two-flop synchroniser with a third flop for rising-edge detection.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/fb_pixel_writer.sv
// Turns each SPI pixel strobe into one raster-ordered write into a
// double-buffered framebuffer; swaps buffers at the end of every frame.
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
  parameter int WIDTH_BITS     = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS    = DEF_HEIGHT_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pixel_clk,
  input  logic [BITS_PER_PIXEL-1:0]           data,
  input  logic                                spi_reset,
  output logic [HEIGHT_BITS+WIDTH_BITS:0]     fb_addr,
  output logic [BITS_PER_PIXEL-1:0]           fb_data,
  output logic                                fb_we,
  output logic                                display_buffer,
  output logic                                frame_done,
  output logic                                overrun,
  output logic [1:0]                          dbg_state,
  output logic [3:0]                          dbg_sync
);

  // Handshake: none upstream; the writer accepts one pixel per pixel_clk rise
  // and fb_we is a single-cycle strobe with fb_addr/fb_data valid alongside it.

  logic w_pix_level;
  logic w_pix_edge;
  logic w_srst_level;
  logic w_srst_rise;

  sync_edge_detect u_sync_pix (
    .clk     (clk),
    .reset   (reset),
    .i_async (pixel_clk),
    .o_level (w_pix_level),
    .o_rise  (w_pix_edge)
  );

  sync_edge_detect u_sync_srst (
    .clk     (clk),
    .reset   (reset),
    .i_async (spi_reset),
    .o_level (w_srst_level),
    .o_rise  (w_srst_rise)
  );

  state_t                          r_state;
  state_t                          w_next_state;
  logic                            w_capture;
  logic                            w_fb_we;
  logic                            w_overrun_hit;
  logic [WIDTH_BITS-1:0]           r_x;
  logic [HEIGHT_BITS-1:0]          r_y;
  logic                            r_write_buffer;
  logic                            r_display_buffer;
  logic                            r_frame_done;
  logic                            r_overrun;
  logic [HEIGHT_BITS+WIDTH_BITS:0] r_fb_addr;
  logic [BITS_PER_PIXEL-1:0]       r_fb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A synchronised spi_reset overrides everything, abandoning any pixel in flight.
  always_comb begin
    w_next_state  = r_state;
    w_capture     = 1'b0;
    w_fb_we       = 1'b0;
    w_overrun_hit = w_pix_edge & ~w_srst_level & (r_state != ST_WAIT);
    if (w_srst_level) begin
      w_next_state = ST_WAIT;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_pix_edge) w_next_state = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          w_capture    = 1'b1;
          w_next_state = ST_WRITE;
        end
        ST_WRITE: begin
          w_fb_we      = ~reset;
          w_next_state = ST_WAIT;
        end
        default: w_next_state = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x              <= '0;
      r_y              <= '0;
      r_write_buffer   <= 1'b0;
      r_display_buffer <= 1'b1;
      r_frame_done     <= 1'b0;
      r_overrun        <= 1'b0;
      r_fb_addr        <= '0;
      r_fb_data        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_overrun_hit) r_overrun <= 1'b1;
      if (w_capture) begin
        r_fb_data <= data;
        r_fb_addr <= {r_write_buffer, r_y, r_x};
      end
      if (w_srst_level) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_fb_we) begin
        r_x <= r_x + 1'b1;
        if (&r_x) begin
          r_y <= r_y + 1'b1;
          if (&r_y) begin
            r_write_buffer   <= ~r_write_buffer;
            r_display_buffer <= r_write_buffer;
            r_frame_done     <= 1'b1;
          end
        end
      end
    end
  end

  assign fb_addr        = r_fb_addr;
  assign fb_data        = r_fb_data;
  assign fb_we          = w_fb_we;
  assign display_buffer = r_display_buffer;
  assign frame_done     = r_frame_done;
  assign overrun        = r_overrun;
  assign dbg_state      = r_state;
  assign dbg_sync       = {w_pix_level, w_pix_edge, w_srst_level, w_srst_rise};

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomised scenario bench for fb_pixel_writer against a raster-order pixel model.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_clk = 1'b0;
  logic [15:0] data = '0;
  logic        spi_reset = 1'b0;
  logic [11:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_we;
  logic        display_buffer;
  logic        frame_done;
  logic        overrun;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_sync;

  int checks = 0;
  int failures = 0;

  // Model: pixels land in raster order; buffer flips after every 2048 pixels.
  logic [27:0] exp_q[$];
  int          m_idx = 0;
  logic        m_wb = 1'b0;
  logic        m_disp = 1'b1;
  logic        fd_pend = 1'b0;
  int          fd_count = 0;
  logic [11:0] last_we_addr = '0;

  fb_pixel_writer dut (
    .clk            (clk),
    .reset          (reset),
    .pixel_clk      (pixel_clk),
    .data           (data),
    .spi_reset      (spi_reset),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .fb_we          (fb_we),
    .display_buffer (display_buffer),
    .frame_done     (frame_done),
    .overrun        (overrun),
    .dbg_state      (dbg_state),
    .dbg_sync       (dbg_sync)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write and every frame_done cycle is checked here.
  always @(negedge clk) begin
    logic        exp_fd;
    logic [27:0] e;
    exp_fd  = fd_pend & ~reset;
    fd_pend = 1'b0;
    checks++;
    if (frame_done !== exp_fd) begin
      failures++;
      $display("FAIL frame_done t=%0t got=%b exp=%b", $time, frame_done, exp_fd);
    end
    if (frame_done === 1'b1) fd_count++;
    if (fb_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_we t=%0t addr=%h data=%h exp=none", $time, fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        if ({fb_addr, fb_data} !== e) begin
          failures++;
          $display("FAIL write t=%0t got addr=%h data=%h exp addr=%h data=%h",
                   $time, fb_addr, fb_data, e[27:16], e[15:0]);
        end
        if (e[26:16] == 11'h7FF) fd_pend = 1'b1;
      end
      last_we_addr = fb_addr;
    end
  end

  task automatic model_push(input logic [15:0] d);
    logic [10:0] idx;
    idx = m_idx[10:0];
    exp_q.push_back({m_wb, idx, d});
    m_idx++;
    if (m_idx == 2048) begin
      m_idx  = 0;
      m_disp = m_wb;
      m_wb   = ~m_wb;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    m_idx  = 0;
    m_wb   = 1'b0;
    m_disp = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    @(negedge clk);
    data      = d;
    pixel_clk = 1'b1;
    model_push(d);
    repeat (4) @(negedge clk);
    pixel_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    if (fb_we !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got we=%b fd=%b ov=%b exp=0,0,0", fb_we, frame_done, overrun);
    end
    checks++;
    if (fb_addr !== 12'h000 || fb_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_bus got addr=%h data=%h exp=0,0", fb_addr, fb_data);
    end
    checks++;
    if (display_buffer !== 1'b1 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got disp=%b st=%0d exp=1,0", display_buffer, dbg_state);
    end
    checks++;
  endtask

  task automatic test_single();
    int cnt;
    cnt = 0;
    @(negedge clk);
    data      = 16'hA5C3;
    pixel_clk = 1'b1;
    model_push(16'hA5C3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (fb_we === 1'b1) break;
    end
    checks++;
    if (cnt < 4 || cnt > 5 || fb_we !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got=%0d cycles we=%b exp=4..5", cnt, fb_we);
    end
    repeat (4) @(negedge clk);
    pixel_clk = 1'b0;
    repeat (3) @(negedge clk);
    drain("single");
    check_val("single_addr", {4'h0, last_we_addr}, 16'h0000);
    check_val("single_disp", {15'h0, display_buffer}, 16'h0001);
  endtask

  task automatic test_row_wrap();
    do_reset();
    for (int i = 0; i < 64; i++) send_pixel(16'(i));
    drain("row");
    check_val("row_last_addr", {4'h0, last_we_addr}, 16'd63);
    send_pixel(16'($urandom));
    drain("row_wrap");
    check_val("row_wrap_addr", {4'h0, last_we_addr}, 16'd64);
  endtask

  task automatic test_full_frame();
    int fd_before;
    do_reset();
    fd_before = fd_count;
    for (int i = 0; i < 2048; i++) send_pixel(16'($urandom));
    drain("frame");
    check_val("frame_last_addr", {4'h0, last_we_addr}, 16'h07FF);
    check_val("frame_done_count", 16'(fd_count - fd_before), 16'd1);
    check_val("frame_disp", {15'h0, display_buffer}, {15'h0, m_disp});
    check_val("frame_disp_const", {15'h0, display_buffer}, 16'h0000);
    send_pixel(16'($urandom));
    drain("frame_next");
    check_val("frame_next_addr", {4'h0, last_we_addr}, 16'h0800);
  endtask

  task automatic test_spi_reset();
    int fd_before;
    fd_before = fd_count;
    for (int i = 0; i < 100; i++) send_pixel(16'($urandom));
    drain("spi_pre");
    check_val("spi_pre_addr", {4'h0, last_we_addr}, 16'h0864);
    @(negedge clk);
    spi_reset = 1'b1;
    repeat (4) @(negedge clk);
    spi_reset = 1'b0;
    repeat (4) @(negedge clk);
    m_idx = 0;
    send_pixel(16'($urandom));
    drain("spi_post");
    check_val("spi_post_addr", {4'h0, last_we_addr}, 16'h0800);
    check_val("spi_no_frame_done", 16'(fd_count - fd_before), 16'd0);
    check_val("spi_disp", {15'h0, display_buffer}, 16'h0000);
  endtask

  task automatic test_overrun();
    logic [15:0] d;
    do_reset();
    d = 16'($urandom);
    @(negedge clk);
    data      = d;
    pixel_clk = 1'b1;
    model_push(d);
    @(negedge clk);
    pixel_clk = 1'b0;
    @(negedge clk);
    pixel_clk = 1'b1;
    repeat (4) @(negedge clk);
    pixel_clk = 1'b0;
    repeat (3) @(negedge clk);
    drain("overrun");
    check_val("overrun_set", {15'h0, overrun}, 16'h0001);
    repeat (20) @(negedge clk);
    send_pixel(16'($urandom));
    drain("overrun_next");
    check_val("overrun_sticky", {15'h0, overrun}, 16'h0001);
    check_val("overrun_next_addr", {4'h0, last_we_addr}, 16'h0001);
  endtask

  task automatic test_reset_mid_write();
    logic hit;
    do_reset();
    check_val("mid_overrun_cleared", {15'h0, overrun}, 16'h0000);
    for (int i = 0; i < 9; i++) send_pixel(16'($urandom));
    drain("mid_pre");
    check_val("mid_pre_addr", {4'h0, last_we_addr}, 16'h0008);
    hit = 1'b0;
    @(negedge clk);
    data      = 16'($urandom);
    pixel_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state === 2'd2) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_reach_write got=no exp=yes");
    end
    pixel_clk = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    check_val("mid_overrun", {15'h0, overrun}, 16'h0000);
    check_val("mid_disp", {15'h0, display_buffer}, 16'h0001);
    send_pixel(16'($urandom));
    drain("mid_post");
    check_val("mid_post_addr", {4'h0, last_we_addr}, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_row_wrap();
    test_full_frame();
    test_spi_reset();
    test_overrun();
    test_reset_mid_write();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
